dmem_arbiter: RTL and testbench

// Two-port arbiter/sequencer in front of the single-port data memory. Port 0 = core

---
 rtl/dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Two-port round-robin arbiter and sequencer in front of a single-port data
// memory. Port 0 is the core load/store unit, port 1 the debug/DMA master.
// One request is accepted at a time. It is driven onto the memory for exactly
// one cycle, and the result is returned to the owning port as a one-cycle
// pulse. Sequence: IDLE (handshake) -> ACCESS (memory cycle) -> RESP (pulse).
//
// Optional feature macro: DMEM_ARB_LOCK_EN
//   When defined, port 0 may lock out port 1. The lock is sampled from
//   req0_lock at each port-0 handshake. When undefined, req0_lock is ignored.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   reqN_valid   port N request valid                  (N = 0,1)
//   reqN_ready   port N accepted this cycle (IDLE only, winner only)
//   reqN_we      1 = write, 0 = read
//   reqN_addr    word address
//   reqN_wdata   write data
//   rspN_valid   one-cycle response pulse to port N
//   rsp_rdata    read data, qualified by rspN_valid
//   rsp_err      address out of range, qualified by rspN_valid
//   req0_lock    port 0 lock request (lock build only)
//   mem_wr_en    memory write enable (ACCESS only)
//   mem_rd_en    memory read enable (ACCESS only)
//   mem_addr     memory address
//   mem_wdata    memory write data
//   mem_rdata    memory read data, combinational from mem_addr
// ============================================================================
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              req0_lock,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic                grant0_s;
    logic                grant1_s;
    logic                req1_eff_s;

    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    logic                owner_r;
    logic                last_grant_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                mem_wr_en_r;
    logic                mem_rd_en_r;
    logic                rsp0_valid_r;
    logic                rsp1_valid_r;
    logic [DATA_W-1:0]   rsp_rdata_r;
    logic                rsp_err_r;

    // Word address falls inside the memory.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a < ADDR_W'(DEPTH));
    endfunction

`ifdef DMEM_ARB_LOCK_EN
    logic                lock_r;

    // Port 1 is invisible to the arbiter while port 0 holds the lock.
    assign req1_eff_s = req1_valid & ~lock_r;
`else
    logic                unused_lock_s;

    // Lock input has no effect in this build.
    assign unused_lock_s = req0_lock;
    assign req1_eff_s    = req1_valid;
`endif

    // Winner selection: a tie goes to the port that did not win last time.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0_valid && req1_eff_s) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_eff_s) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Ready is held low while reset is asserted so no output leaks during reset.
    assign req0_ready = grant0_s & reset;
    assign req1_ready = grant1_s & reset;

    // Request fields of the winning port.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (grant1_s) begin
            sel_we_s    = req1_we;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
        end else begin
            sel_we_s    = req0_we;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
        end
    end

    // Next-state logic; a grant is only given to a valid port, so grant == handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transaction latch, memory strobes and response registers.
    // Memory enables are set on the handshake edge and cleared on the edge
    // that leaves ACCESS, so they are high for exactly the ACCESS cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            mem_wr_en_r  <= 1'b0;
            mem_rd_en_r  <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_rdata_r  <= {DATA_W{1'b0}};
            rsp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    if (grant0_s || grant1_s) begin
                        owner_r      <= grant1_s;
                        last_grant_r <= grant1_s;
                        addr_r       <= sel_addr_s;
                        wdata_r      <= sel_wdata_s;
                        mem_wr_en_r  <= sel_we_s & in_range(sel_addr_s);
                        mem_rd_en_r  <= ~sel_we_s & in_range(sel_addr_s);
                    end else begin
                        mem_wr_en_r  <= 1'b0;
                        mem_rd_en_r  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    mem_wr_en_r  <= 1'b0;
                    mem_rd_en_r  <= 1'b0;
                    // mem_rd_en_r is exactly "in-range read" for this transaction.
                    rsp_rdata_r  <= mem_rd_en_r ? mem_rdata : {DATA_W{1'b0}};
                    rsp_err_r    <= ~in_range(addr_r);
                    rsp0_valid_r <= ~owner_r;
                    rsp1_valid_r <= owner_r;
                end
                ST_RESP: begin
                    mem_wr_en_r  <= 1'b0;
                    mem_rd_en_r  <= 1'b0;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                end
                default: begin
                    mem_wr_en_r  <= 1'b0;
                    mem_rd_en_r  <= 1'b0;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Lock follows req0_lock at every port-0 handshake; port 1 cannot touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_r <= 1'b0;
        end else if (grant0_s) begin
            lock_r <= req0_lock;
        end else begin
            lock_r <= lock_r;
        end
    end
`endif

    assign mem_wr_en  = mem_wr_en_r;
    assign mem_rd_en  = mem_rd_en_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter
// ----------------------------------------------------------------------------
// Directed self-checking bench for dmem_arbiter with a small behavioural
// 32-word memory attached to the memory-side port.
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [31:0] req1_addr, req1_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        req0_lock;
    logic        mem_wr_en, mem_rd_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .req0_lock  (req0_lock),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on rising edge, preloaded on reset.
    assign mem_rdata = (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[5] <= 32'hDEAD_BEEF;
            mem[6] <= 32'h0000_0066;
        end else if (mem_wr_en) begin
            mem[mem_addr[4:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // One full transaction on port p starting in IDLE. If keep=0 the request
    // is withdrawn and scrambled right after the handshake.
    task automatic xact(input int p, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic keep,
                        input logic [31:0] exp_rdata, input logic exp_err);
        logic exp_wr, exp_rd;
        exp_wr = we && (a < 32'd32);
        exp_rd = !we && (a < 32'd32);
        drive(p, 1'b1, we, a, d);
        #1;
        chk("ready_winner", (p == 0) ? req0_ready : req1_ready, 64'd1);
        chk("ready_loser",  (p == 0) ? req1_ready : req0_ready, 64'd0);
        tick();
        if (!keep) drive(p, 1'b0, ~we, a ^ 32'h1, ~d);
        #1;
        chk("acc_ready0", req0_ready, 64'd0);
        chk("acc_ready1", req1_ready, 64'd0);
        chk("acc_wr_en",  mem_wr_en, exp_wr);
        chk("acc_rd_en",  mem_rd_en, exp_rd);
        chk("acc_addr",   mem_addr, a);
        if (exp_wr) chk("acc_wdata", mem_wdata, d);
        chk("acc_rsp0",   rsp0_valid, 64'd0);
        chk("acc_rsp1",   rsp1_valid, 64'd0);
        tick();
        chk("resp_rsp0",  rsp0_valid, (p == 0) ? 64'd1 : 64'd0);
        chk("resp_rsp1",  rsp1_valid, (p == 1) ? 64'd1 : 64'd0);
        chk("resp_rdata", rsp_rdata, exp_rdata);
        chk("resp_err",   rsp_err, exp_err);
        chk("resp_wr_en", mem_wr_en, 64'd0);
        chk("resp_rd_en", mem_rd_en, 64'd0);
        tick();
        chk("post_rsp0",  rsp0_valid, 64'd0);
        chk("post_rsp1",  rsp1_valid, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        req0_lock = 1'b0;
        drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd6, 32'h0);
        tick();
        tick();
        // Reset state: everything low even with both requests valid.
        chk("rst_ready0", req0_ready, 64'd0);
        chk("rst_ready1", req1_ready, 64'd0);
        chk("rst_wr_en",  mem_wr_en, 64'd0);
        chk("rst_rd_en",  mem_rd_en, 64'd0);
        chk("rst_rsp0",   rsp0_valid, 64'd0);
        chk("rst_rsp1",   rsp1_valid, 64'd0);
        chk("rst_rdata",  rsp_rdata, 64'd0);
        chk("rst_addr",   mem_addr, 64'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'h0);
        reset = 1'b1;

        // Read addr 5 on port 0 right after reset release.
        xact(0, 1'b0, 32'd5, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Both ports continuously: port 0 won last, so 1,0,1,0.
        drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd6, 32'h0);
        xact(1, 1'b0, 32'd6, 32'h0, 1'b1, 32'h0000_0066, 1'b0);
        xact(0, 1'b0, 32'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xact(1, 1'b0, 32'd6, 32'h0, 1'b1, 32'h0000_0066, 1'b0);
        xact(0, 1'b0, 32'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'h0);

        // Out-of-range write on port 1.
        xact(1, 1'b1, 32'd40, 32'hABCD_0123, 1'b0, 32'h0, 1'b1);

        // Write addr 3 via port 1, read back via port 0.
        xact(1, 1'b1, 32'd3, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
        xact(0, 1'b0, 32'd3, 32'h0, 1'b0, 32'h1234_5678, 1'b0);

        // Address 0 write is forwarded, no error.
        xact(0, 1'b1, 32'd0, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
        chk("mem0_written", mem[0], 64'hA5A5_A5A5);

        // Reset during ACCESS of a port-0 write.
        drive(0, 1'b1, 1'b1, 32'd9, 32'h0000_0055);
        #1;
        chk("r5_ready0", req0_ready, 64'd1);
        tick();
        drive(0, 1'b0, 1'b0, 32'd0, 32'h0);
        #1;
        chk("r5_wr_en_before", mem_wr_en, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("r5_wr_en_drop", mem_wr_en, 64'd0);
        chk("r5_rd_en_drop", mem_rd_en, 64'd0);
        tick();
        chk("r5_no_rsp0", rsp0_valid, 64'd0);
        chk("r5_no_rsp1", rsp1_valid, 64'd0);
        chk("r5_err",     rsp_err, 64'd0);
        #1;
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd6, 32'h0);
        #1;
        chk("r5_tie_ready0", req0_ready, 64'd1);
        chk("r5_tie_ready1", req1_ready, 64'd0);

`ifdef DMEM_ARB_LOCK_EN
        // Three locked port-0 requests starve port 1; an unlocking request
        // hands the next tie to port 1.
        req0_lock = 1'b1;
        xact(0, 1'b0, 32'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b0, 32'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b0, 32'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        req0_lock = 1'b0;
        xact(0, 1'b0, 32'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xact(1, 1'b0, 32'd6, 32'h0, 1'b1, 32'h0000_0066, 1'b0);
`else
        // Lock input has no effect: the tie after a port-0 grant goes to port 1.
        req0_lock = 1'b1;
        xact(0, 1'b0, 32'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xact(1, 1'b0, 32'd6, 32'h0, 1'b1, 32'h0000_0066, 1'b0);
        req0_lock = 1'b0;
`endif
        drive(0, 1'b0, 1'b0, 32'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
